// File: rtl/fifo_pkg.sv
// Shared constants for the FIFO stream reader.
// Occupancy encodings, default data width and transfer counter width.
package fifo_pkg;

   localparam int DATA_WIDTH_DEF = 8;
   localparam int CNT_W          = 16;

   localparam logic [1:0] OCC_EMPTY = 2'd0;
   localparam logic [1:0] OCC_ONE   = 2'd1;
   localparam logic [1:0] OCC_TWO   = 2'd2;

endpackage

// File: rtl/stream_skid_buf2.sv
// Two-entry register buffer with push/pop/clear.
// Exposes occupancy and the head entry; clear wins over push/pop.
module stream_skid_buf2
   import fifo_pkg::*;
#(
   parameter int DW = DATA_WIDTH_DEF
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          clear_i,
   input  logic          push_i,
   input  logic [DW-1:0] push_data_i,
   input  logic          pop_i,
   output logic [1:0]    occ_o,
   output logic [DW-1:0] head_o
);

   logic [DW-1:0] r_mem [2];
   logic          r_head;
   logic          r_tail;
   logic [1:0]    r_occ;
   logic [1:0]    w_occ_nxt;

   // next occupancy from push/pop combination
   always_comb begin
      w_occ_nxt = r_occ;
      if (push_i && !pop_i) begin
         unique case (r_occ)
            OCC_EMPTY: w_occ_nxt = OCC_ONE;
            default:   w_occ_nxt = OCC_TWO;
         endcase
      end else if (!push_i && pop_i) begin
         unique case (r_occ)
            OCC_TWO: w_occ_nxt = OCC_ONE;
            default: w_occ_nxt = OCC_EMPTY;
         endcase
      end
   end

   // storage, head/tail pointers and occupancy
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_head   <= 1'b0;
         r_tail   <= 1'b0;
         r_occ    <= OCC_EMPTY;
      end else if (clear_i) begin
         r_head <= 1'b0;
         r_tail <= 1'b0;
         r_occ  <= OCC_EMPTY;
      end else begin
         if (push_i) begin
            r_mem[r_tail] <= push_data_i;
            r_tail        <= ~r_tail;
         end
         if (pop_i) begin
            r_head <= ~r_head;
         end
         r_occ <= w_occ_nxt;
      end
   end

   assign occ_o  = r_occ;
   assign head_o = r_mem[r_head];

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a synchronous FIFO into a valid/ready stream via a 2-entry buffer.
// Optional pop counter port xfer_cnt_o with FIFO_STREAM_READER_CNT_EN.
module fifo_stream_reader
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int BUF_DEPTH  = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  fifo_empty_i,
   input  logic [DATA_WIDTH-1:0] fifo_rdata_i,
   output logic                  fifo_rd_en_o,
   input  logic                  flush_i,
   output logic                  m_valid_o,
   output logic [DATA_WIDTH-1:0] m_data_o,
   input  logic                  m_ready_i,
`ifdef FIFO_STREAM_READER_CNT_EN
   output logic [CNT_W-1:0]      xfer_cnt_o,
`endif
   output logic                  underrun_o
);

   if (BUF_DEPTH != 2) begin : g_depth_chk
      $error("fifo_stream_reader: BUF_DEPTH must be 2");
   end

   logic       r_inflight;
   logic       r_discard;
   logic       r_underrun;
   logic [1:0] w_occ;
   logic       w_pop;
   logic       w_capture;
   logic [2:0] w_level;

   assign w_pop     = m_valid_o & m_ready_i;
   assign w_capture = r_inflight & ~r_discard & ~flush_i;
   assign w_level   = {1'b0, w_occ} + {2'b00, r_inflight}
                    - {2'b00, w_pop};

   assign fifo_rd_en_o = rst_ni & ~fifo_empty_i & ~flush_i
                       & (w_level < 3'd2);
   assign m_valid_o    = (w_occ != OCC_EMPTY);
   assign underrun_o   = r_underrun;

   stream_skid_buf2 #(
      .DW (DATA_WIDTH)
   ) u_buf (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .clear_i     (flush_i),
      .push_i      (w_capture),
      .push_data_i (fifo_rdata_i),
      .pop_i       (w_pop),
      .occ_o       (w_occ),
      .head_o      (m_data_o)
   );

   // read-in-flight tracking, post-flush discard and sticky underrun
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_inflight <= 1'b0;
         r_discard  <= 1'b0;
         r_underrun <= 1'b0;
      end else begin
         r_inflight <= fifo_rd_en_o;
         r_discard  <= flush_i & r_inflight;
         r_underrun <= r_underrun | (fifo_rd_en_o & fifo_empty_i);
      end
   end

`ifdef FIFO_STREAM_READER_CNT_EN
   logic [CNT_W-1:0] r_xfer_cnt;

   // wrapping pop counter, survives flush
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_xfer_cnt <= '0;
      end else if (w_pop && !flush_i) begin
         r_xfer_cnt <= r_xfer_cnt + 1'b1;
      end
   end

   assign xfer_cnt_o = r_xfer_cnt;
`endif

endmodule
